// File: rtl/stft_cos_mac.sv
// stft_cos_mac: single-bin DFT correlator driving the STFT cosine table.
// Optional accumulator saturation: define STFT_MAC_SAT_EN.
module stft_cos_mac #(
    parameter int N_SAMPLES = 256,
    parameter int ACC_W     = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [9:0]              phase_step,
    input  logic                    smp_valid,
    input  logic signed [15:0]      smp_data,
    output logic                    smp_ready,
    output logic                    cos_en,
    output logic [9:0]              cos_deg_half,
    input  logic signed [15:0]      cos_val,
    output logic                    busy,
    output logic                    done,
    output logic signed [ACC_W-1:0] acc_out,
    output logic                    ovf
);

    localparam int CW = $clog2(N_SAMPLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t                  r_state;
    logic [9:0]              r_phase;
    logic [9:0]              r_step;
    logic [CW-1:0]           r_count;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] r_acc_out;
    logic                    r_done;
    logic                    r_ovf;

    logic                    r_v1;
    logic                    r_l1;
    logic signed [15:0]      r_smp;
    logic                    r_v2;
    logic                    r_l2;
    logic signed [31:0]      r_prod;

    logic                    w_accept;
    logic                    w_last;
    logic [9:0]              w_step_in;
    logic [10:0]             w_phase_sum;
    logic [9:0]              w_phase_nxt;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic                    w_clamp;

    assign w_accept     = smp_valid && (r_state == S_RUN);
    assign w_last       = w_accept && (r_count == CW'(N_SAMPLES - 1));
    assign w_step_in    = (phase_step >= 10'd720) ? phase_step - 10'd720
                                                  : phase_step;
    assign w_phase_sum  = {1'b0, r_phase} + {1'b0, r_step};
    assign w_phase_nxt  = (w_phase_sum >= 11'd720) ? 10'(w_phase_sum - 11'd720)
                                                   : w_phase_sum[9:0];

    assign smp_ready    = (r_state == S_RUN);
    assign cos_en       = w_accept;
    assign cos_deg_half = r_phase;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign acc_out      = r_acc_out;
    assign ovf          = r_ovf;

`ifdef STFT_MAC_SAT_EN
    logic signed [ACC_W:0] w_sum;

    // Widened add; a sign mismatch in the top two bits means the add clamped.
    always_comb begin
        w_sum     = (ACC_W+1)'(r_acc) + (ACC_W+1)'(r_prod);
        w_clamp   = w_sum[ACC_W] ^ w_sum[ACC_W-1];
        w_acc_nxt = w_sum[ACC_W-1:0];
        if (w_clamp) begin
            w_acc_nxt = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                     : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    // Plain modulo-2^ACC_W accumulation; overflow never flagged.
    always_comb begin
        w_acc_nxt = r_acc + ACC_W'(r_prod);
        w_clamp   = 1'b0;
    end
`endif

    // Frame control FSM, phase stepping, accumulator and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_phase   <= '0;
            r_step    <= '0;
            r_count   <= '0;
            r_acc     <= '0;
            r_acc_out <= '0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_RUN;
                        r_phase <= '0;
                        r_count <= '0;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_step  <= w_step_in;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_phase <= w_phase_nxt;
                        r_count <= r_count + 1'b1;
                        if (w_last) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                end
                default: r_state <= S_IDLE;
            endcase
            if (r_v2) begin
                r_acc <= w_acc_nxt;
                r_ovf <= r_ovf | w_clamp;
                if (r_l2) begin
                    r_acc_out <= w_acc_nxt;
                    r_done    <= 1'b1;
                    r_state   <= S_IDLE;
                end
            end
        end
    end

    // Sample and product pipe; valid bits keep bubbles out of the sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_l1   <= 1'b0;
            r_smp  <= '0;
            r_v2   <= 1'b0;
            r_l2   <= 1'b0;
            r_prod <= '0;
        end else begin
            r_v1 <= w_accept;
            r_l1 <= w_last;
            if (w_accept) r_smp <= smp_data;
            r_v2 <= r_v1;
            r_l2 <= r_v1 & r_l1;
            if (r_v1) r_prod <= 32'(r_smp) * 32'(cos_val);
        end
    end

endmodule

// File: tb/tb_stft_cos_mac.sv
// tb_stft_cos_mac: scoreboard bench for stft_cos_mac (N_SAMPLES=4, ACC_W=32).
module tb_stft_cos_mac;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [9:0]         phase_step = '0;
    logic               smp_valid = 1'b0;
    logic signed [15:0] smp_data = '0;
    logic               smp_ready;
    logic               cos_en;
    logic [9:0]         cos_deg_half;
    logic signed [15:0] cos_val = '0;
    logic               busy;
    logic               done;
    logic signed [31:0] acc_out;
    logic               ovf;

    stft_cos_mac #(.N_SAMPLES(4), .ACC_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .phase_step(phase_step),
        .smp_valid(smp_valid), .smp_data(smp_data), .smp_ready(smp_ready),
        .cos_en(cos_en), .cos_deg_half(cos_deg_half), .cos_val(cos_val),
        .busy(busy), .done(done), .acc_out(acc_out), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  last_acc_cyc = 0;
    int  frames_done = 0;
    bit  model_big = 1'b0;
    int  idx_q[$];
    longint res_q[$];
    bit  ovf_q[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic signed [15:0] tbl(input logic [9:0] a);
        if (a == 10'd0) return model_big ? 16'sd32767 : 16'sd16384;
        if (a == 10'd360) return -16'sd16384;
        return 16'sd0;
    endfunction

    // Cosine table model: registered, one cycle latency.
    always @(posedge clk) begin
        if (cos_en) cos_val <= tbl(cos_deg_half);
    end

    always @(posedge clk) cyc++;

    // Monitor: pops expectations whenever the DUT reads the table or finishes.
    always @(negedge clk) begin
        if (!rst) begin
            if (busy && !smp_valid) chk("cos_en_bubble", cos_en, 0);
            if (cos_en) begin
                last_acc_cyc = cyc;
                if (idx_q.size() == 0) chk("cos_en_unexpected", 1, 0);
                else chk("cos_deg_half", cos_deg_half, idx_q.pop_front());
            end
            if (done) begin
                chk("done_latency", cyc - last_acc_cyc, 3);
                if (res_q.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    chk("acc_out", acc_out, res_q.pop_front());
                    chk("ovf", ovf, ovf_q.pop_front());
                end
                frames_done++;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_smp_ready"}, smp_ready, 0);
        chk({tag, "_cos_en"}, cos_en, 0);
        chk({tag, "_cos_deg_half"}, cos_deg_half, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_acc_out"}, acc_out, 0);
        chk({tag, "_ovf"}, ovf, 0);
    endtask

    task automatic run_frame(input logic [9:0] step, input int smp[4],
                             input int idx[4], input logic [31:0] vpat,
                             input int vlen, input longint exp_acc,
                             input bit exp_ovf, input int abort_after);
        int k;
        int target;
        bit v;
        if (abort_after == 0) begin
            res_q.push_back(exp_acc);
            ovf_q.push_back(exp_ovf);
        end
        target = frames_done + 1;
        @(posedge clk); #1;
        start = 1'b1;
        phase_step = step;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        for (int c = 0; k < 4; c++) begin
            v = (c < vlen) ? vpat[c] : 1'b1;
            smp_valid = v;
            if (v) begin
                smp_data = 16'(smp[k]);
                idx_q.push_back(idx[k]);
                k++;
            end
            @(posedge clk); #1;
            if (abort_after != 0 && k == abort_after) begin
                smp_valid = 1'b0;
                rst = 1'b1;
                #1;
                check_reset_outputs("midrst");
                @(posedge clk); #1;
                rst = 1'b0;
                return;
            end
        end
        smp_valid = 1'b0;
        for (int i = 0; i < 20 && frames_done < target; i++) begin
            @(negedge clk); #1;
        end
        chk("done_seen", frames_done, target);
    endtask

    initial begin
        #22;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        run_frame(10'd0, '{100, 100, 100, 100}, '{0, 0, 0, 0},
                  32'd0, 0, 64'sd6553600, 1'b0, 0);
        run_frame(10'd360, '{100, 100, 100, 100}, '{0, 360, 0, 360},
                  32'd0, 0, 64'sd0, 1'b0, 0);
        run_frame(10'd500, '{100, 100, 100, 100}, '{0, 500, 280, 60},
                  32'd0, 0, 64'sd1638400, 1'b0, 0);
        run_frame(10'd1000, '{100, 100, 100, 100}, '{0, 280, 560, 120},
                  32'd0, 0, 64'sd1638400, 1'b0, 0);
        run_frame(10'd0, '{100, 100, 100, 100}, '{0, 0, 0, 0},
                  32'b1011001, 7, 64'sd6553600, 1'b0, 0);
        run_frame(10'd0, '{100, 100, 100, 100}, '{0, 0, 0, 0},
                  32'd0, 0, 64'sd0, 1'b0, 2);
        run_frame(10'd0, '{100, 100, 100, 100}, '{0, 0, 0, 0},
                  32'd0, 0, 64'sd6553600, 1'b0, 0);
        run_frame(10'd360, '{-32768, 32767, -32768, 32767}, '{0, 360, 0, 360},
                  32'd0, 0, -64'sd2147450880, 1'b0, 0);
        run_frame(10'd360, '{-32768, -32768, -32768, -32768}, '{0, 360, 0, 360},
                  32'd0, 0, 64'sd0, 1'b0, 0);
        model_big = 1'b1;
`ifdef STFT_MAC_SAT_EN
        run_frame(10'd0, '{32767, 32767, 32767, 32767}, '{0, 0, 0, 0},
                  32'd0, 0, 64'sd2147483647, 1'b1, 0);
`else
        run_frame(10'd0, '{32767, 32767, 32767, 32767}, '{0, 0, 0, 0},
                  32'd0, 0, -64'sd262140, 1'b0, 0);
`endif
        model_big = 1'b0;
        run_frame(10'd0, '{100, 100, 100, 100}, '{0, 0, 0, 0},
                  32'd0, 0, 64'sd6553600, 1'b0, 0);

        repeat (3) @(posedge clk);
        chk("idx_q_empty", idx_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
